// File: rtl/led_pkg.sv
// Shared types and helpers for the LED blink sequencer.
package led_pkg;

  localparam int LED_PER_W = 16;
  localparam int LED_CNT_W = 8;

  typedef enum logic [1:0] {
    LS_IDLE,
    LS_ON,
    LS_OFF,
    LS_DONE
  } led_state_e;

  // Command as seen on the control interface: ON length, OFF length, pair count.
  typedef struct packed {
    logic [LED_PER_W-1:0] on_ticks;
    logic [LED_PER_W-1:0] off_ticks;
    logic [LED_CNT_W-1:0] rep;
  } led_cmd_t;

  // Prescaler counter width; never narrower than one bit so CLK_DIV==1 still elaborates.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: one-cycle tick every CLK_DIV clocks, restartable by clr.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            W    = presc_width(CLK_DIV);
  localparam logic [W-1:0]  LAST = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  // With CLK_DIV==1 LAST is 0, so the counter sits at 0 and tick stays high.
  assign tick = (cnt == LAST);

  // Count 0..CLK_DIV-1 and wrap; clr restarts the time base at a command accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/led_blink_seq.sv
// Command-driven LED blink sequencer: timed ON/OFF pairs, repeat count, abort, done pulse.
module led_blink_seq
  import led_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int PER_W   = LED_PER_W,
  parameter int CNT_W   = LED_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [PER_W-1:0] cmd_on_ticks,
  input  logic [PER_W-1:0] cmd_off_ticks,
  input  logic [CNT_W-1:0] cmd_repeat,
  input  logic             abort,
  output logic             led,
  output logic             busy,
  output logic             done
);

  led_state_e       state_q, state_d;
  logic [PER_W-1:0] on_q, off_q;
  logic [CNT_W-1:0] rep_q;
  logic [PER_W-1:0] phase_cnt;
  logic [CNT_W-1:0] rep_cnt, rep_inc;
  logic             accept, tick, phase_end, pair_end;

  // Last tick of a phase; zero-length phases never match.
  function automatic logic last_tick(input logic [PER_W-1:0] cnt,
                                     input logic [PER_W-1:0] len);
    return (len != '0) && (cnt == len - PER_W'(1));
  endfunction

  assign cmd_ready = (state_q == LS_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rep_inc   = rep_cnt + CNT_W'(1);

  assign led  = (state_q == LS_ON);
  assign busy = (state_q == LS_ON) || (state_q == LS_OFF);
  assign done = (state_q == LS_DONE);

  led_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .tick  (tick)
  );

  // Next-state decode; abort wins over any phase end in the same cycle.
  always_comb begin
    state_d   = state_q;
    phase_end = 1'b0;
    pair_end  = 1'b0;
    unique case (state_q)
      LS_IDLE: begin
        if (cmd_valid) begin
          if (cmd_on_ticks != '0)       state_d = LS_ON;
          else if (cmd_off_ticks != '0) state_d = LS_OFF;
          else                          state_d = LS_DONE;
        end
      end
      LS_ON: begin
        if (abort) begin
          state_d = LS_IDLE;
        end else if (tick && last_tick(phase_cnt, on_q)) begin
          phase_end = 1'b1;
          if (off_q != '0) state_d  = LS_OFF;
          else             pair_end = 1'b1;
        end
      end
      LS_OFF: begin
        if (abort) begin
          state_d = LS_IDLE;
        end else if (tick && last_tick(phase_cnt, off_q)) begin
          phase_end = 1'b1;
          pair_end  = 1'b1;
        end
      end
      LS_DONE: state_d = LS_IDLE;
      default: state_d = LS_IDLE;
    endcase
    // A repeat of 0 never matches, so the sequence runs until abort or reset.
    if (pair_end) begin
      if ((rep_q != '0) && (rep_inc == rep_q)) state_d = LS_DONE;
      else if (on_q != '0)                     state_d = LS_ON;
      else                                     state_d = LS_OFF;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LS_IDLE;
    else        state_q <= state_d;
  end

  // Command fields, captured on the accepting edge only.
  always_ff @(posedge clk) begin
    if (accept) begin
      on_q  <= cmd_on_ticks;
      off_q <= cmd_off_ticks;
      rep_q <= cmd_repeat;
    end
  end

  // Phase counter: ticks within the current phase, restarted at every phase boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
    end else if (accept || phase_end || abort) begin
      phase_cnt <= '0;
    end else if (tick && busy) begin
      phase_cnt <= phase_cnt + PER_W'(1);
    end
  end

  // Completed ON/OFF pairs; wraps freely when repeat is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (accept) begin
      rep_cnt <= '0;
    end else if (pair_end) begin
      rep_cnt <= rep_inc;
    end
  end

endmodule

// File: tb/tb_led_blink_seq.sv
// Directed bench for led_blink_seq with a cycle-level waveform model.
module tb_led_blink_seq;

  localparam int CLK_DIV = 4;
  localparam int PER_W   = 16;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             abort = 1'b0;
  logic [PER_W-1:0] cmd_on_ticks = '0;
  logic [PER_W-1:0] cmd_off_ticks = '0;
  logic [CNT_W-1:0] cmd_repeat = '0;
  logic             cmd_ready, led, busy, done;

  int nvec = 0;
  int nerr = 0;

  // Expected {led,busy,done} per cycle; front = current cycle, empty = idle.
  logic [2:0] exp_q[$];

  led_blink_seq #(
    .CLK_DIV (CLK_DIV),
    .PER_W   (PER_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_on_ticks  (cmd_on_ticks),
    .cmd_off_ticks (cmd_off_ticks),
    .cmd_repeat    (cmd_repeat),
    .abort         (abort),
    .led           (led),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Waveform of a whole command: on*CLK_DIV lit cycles, off*CLK_DIV dark busy cycles per pair,
  // then one done cycle. Endless commands get a long lit/dark tail with no done.
  function automatic void build(input int on, input int off, input int rep);
    exp_q.delete();
    if (on == 0 && off == 0) begin
      exp_q.push_back(3'b001);
      return;
    end
    for (int p = 0; (rep == 0) ? (exp_q.size() < 2000) : (p < rep); p++) begin
      for (int i = 0; i < on * CLK_DIV; i++)  exp_q.push_back(3'b110);
      for (int i = 0; i < off * CLK_DIV; i++) exp_q.push_back(3'b010);
    end
    if (rep != 0) exp_q.push_back(3'b001);
  endfunction

  // Model advance on each active edge (or immediate flush on reset).
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (cmd_valid) build(int'(cmd_on_ticks), int'(cmd_off_ticks), int'(cmd_repeat));
    end else if (abort) begin
      exp_q.delete();
    end else begin
      void'(exp_q.pop_front());
    end
  end

  // Per-cycle compare of all outputs against the model, away from the active edge.
  initial forever begin
    logic [2:0] e;
    logic       r;
    @(negedge clk);
    e = (exp_q.size() == 0) ? 3'b000 : exp_q[0];
    r = (exp_q.size() == 0);
    nvec++;
    if ({led, busy, done} !== e || cmd_ready !== r) begin
      nerr++;
      $display("FAIL cycle@%0t: got led/busy/done/ready=%b%b%b%b want %b%b%b%b",
               $time, led, busy, done, cmd_ready, e[2], e[1], e[0], r);
    end
  end

  task automatic check(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a command and hold it until accepted; returns on the first cycle after acceptance.
  task automatic send(input int on, input int off, input int rep);
    int n;
    cmd_on_ticks  = PER_W'(on);
    cmd_off_ticks = PER_W'(off);
    cmd_repeat    = CNT_W'(rep);
    cmd_valid     = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      nvec++;
      nerr++;
      $display("FAIL send_timeout: got cmd_ready=0 want 1 within 200 cycles");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and quiet idle.
    step(3);
    rst_n = 1'b1;
    step(1);
    check("rst_led",   led,       1'b0);
    check("rst_busy",  busy,      1'b0);
    check("rst_done",  done,      1'b0);
    check("rst_ready", cmd_ready, 1'b1);
    step(5);
    check("idle_busy", busy,      1'b0);
    check("idle_ready", cmd_ready, 1'b1);

    // {2,3,2}: ON 1..8, OFF 9..20, ON 21..28, OFF 29..40, done at 41.
    send(2, 3, 2);
    check("t2_k1_led",   led,  1'b1);
    step(7);  check("t2_k8_led",   led,  1'b1);
    step(1);  check("t2_k9_led",   led,  1'b0);
              check("t2_k9_busy",  busy, 1'b1);
    step(12); check("t2_k21_led",  led,  1'b1);
    step(19); check("t2_k40_busy", busy, 1'b1);
              check("t2_k40_led",  led,  1'b0);
    step(1);  check("t2_k41_done", done, 1'b1);
              check("t2_k41_busy", busy, 1'b0);
    step(1);  check("t2_k42_done", done, 1'b0);
              check("t2_k42_ready", cmd_ready, 1'b1);

    // {0,2,1}: dark but busy for 8 cycles, then done.
    send(0, 2, 1);
    check("t3a_k1_led",  led,  1'b0);
    check("t3a_k1_busy", busy, 1'b1);
    step(7);  check("t3a_k8_busy", busy, 1'b1);
    step(1);  check("t3a_k9_done", done, 1'b1);
    step(1);
    // {0,0,5}: straight to done.
    send(0, 0, 5);
    check("t3b_k1_done", done, 1'b1);
    check("t3b_k1_busy", busy, 1'b0);
    step(1);  check("t3b_k2_ready", cmd_ready, 1'b1);

    // {1,1,0}: endless; abort during ON of the 13th pair.
    send(1, 1, 0);
    step(99);
    check("t4_k100_led", led, 1'b1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("t4_abort_led",   led,       1'b0);
    check("t4_abort_busy",  busy,      1'b0);
    check("t4_abort_ready", cmd_ready, 1'b1);
    check("t4_abort_done",  done,      1'b0);
    step(3);  check("t4_nodone", done, 1'b0);
    // Abort in IDLE with a command present: command is taken.
    abort         = 1'b1;
    cmd_on_ticks  = PER_W'(1);
    cmd_off_ticks = PER_W'(1);
    cmd_repeat    = CNT_W'(1);
    cmd_valid     = 1'b1;
    step(1);
    abort     = 1'b0;
    cmd_valid = 1'b0;
    check("t4_idle_abort_led",  led,  1'b1);
    check("t4_idle_abort_busy", busy, 1'b1);
    step(8);  check("t4_idle_abort_done", done, 1'b1);
    step(1);

    // {1,2,1} running; a new command is held from cycle 3 until the block is idle again.
    send(1, 2, 1);
    step(2);
    cmd_on_ticks  = PER_W'(2);
    cmd_off_ticks = PER_W'(1);
    cmd_repeat    = CNT_W'(1);
    cmd_valid     = 1'b1;
    check("t5_held_ready", cmd_ready, 1'b0);
    check("t5_held_busy",  busy,      1'b1);
    step(10); check("t5_k13_done",  done,      1'b1);
              check("t5_k13_ready", cmd_ready, 1'b0);
    step(1);  check("t5_k14_ready", cmd_ready, 1'b1);
    step(1);
    cmd_valid = 1'b0;
    check("t5_new_k1_led",  led,  1'b1);
    step(7);  check("t5_new_k8_led",  led,  1'b1);
    step(1);  check("t5_new_k9_led",  led,  1'b0);
              check("t5_new_k9_busy", busy, 1'b1);
    step(3);  check("t5_new_k12_busy", busy, 1'b1);
    step(1);  check("t5_new_k13_done", done, 1'b1);
    step(1);

    // {3,3,1}: reset between edges while in OFF.
    send(3, 3, 1);
    step(14);
    check("t6_off_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_led",   led,       1'b0);
    check("t6_rst_busy",  busy,      1'b0);
    check("t6_rst_done",  done,      1'b0);
    check("t6_rst_ready", cmd_ready, 1'b1);
    step(2);
    rst_n = 1'b1;
    step(1);
    send(1, 1, 1);
    check("t6_k1_led", led, 1'b1);
    step(3);  check("t6_k4_led",  led,  1'b1);
    step(1);  check("t6_k5_led",  led,  1'b0);
              check("t6_k5_busy", busy, 1'b1);
    step(3);  check("t6_k8_busy", busy, 1'b1);
    step(1);  check("t6_k9_done", done, 1'b1);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
